regfile_write_scheduler: RTL and testbench
==========================================

Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 8x8 general register file.
- After reset or a clear request, it zeroes every register, one per cycle.
- After that, it arbitrates between two write requesters with round-robin and valid/ready handshakes: core writeback (ALU or immediate) and the memory load unit.
- All register-file write controls are driven from registered outputs, one cycle after acceptance.

Parameters:
- W, 8, data width of a register
- D, 3, register address width (2**D registers)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous request to re-zero all registers
- core_valid  in  1  core write request valid
- core_ready  out  1  core request accepted this cycle (combinational)
- core_addr  in  D  core target register
- core_data  in  W  core write data or immediate value
- core_imm  in  1  1 = immediate write path
- core_zero  in  1  1 = write to register 0 regardless of core_addr (non-immediate only)
- mem_valid  in  1  load-unit write request valid
- mem_ready  out  1  load-unit request accepted this cycle (combinational)
- mem_addr  in  D  load target register
- mem_data  in  W  loaded data
- mem_zero  in  1  1 = write to register 0
- reg_write  out  1  register-file write enable (registered)
- zero_store  out  1  register-file zero_store (registered)
- immediate  out  1  register-file immediate select (registered)
- data_in  out  W  register-file data_in (registered)
- immediate_val  out  W  register-file immediate_val (registered)
- write_addr  out  D  register-file write_addr (registered)
- init_busy  out  1  1 while in INIT (decoded from state)
- conflict_cnt  out  8  saturating count of cycles where both requesters were valid in RUN

Behaviour:

Reset (reset_n low, asynchronous):
- State goes to INIT, init counter to 0, rr pointer to "core first", conflict_cnt to 0.
- All registered outputs are 0. init_busy = 1. Both ready outputs = 0.

INIT state:
- Each rising edge loads reg_write=1, immediate=0, zero_store=0, data_in=0, immediate_val=0, write_addr=cnt[D-1:0], then increments cnt.
- Addresses 0..2**D-1 are issued on the first 2**D edges after reset release.
- The edge that issues address 2**D-1 moves the state to RUN.
- core_ready = mem_ready = 0 throughout. Pending requests are held by the requesters, not dropped.

RUN state, arbitration and handshake:
- Grant is combinational.
- If only one requester is valid, that requester gets ready = 1.
- If both are valid, the requester that was not granted most recently wins. After reset, core wins the first tie.
- At most one ready per cycle. A transfer occurs when valid && ready.
- On every grant, the rr pointer records the winner.
- conflict_cnt increments on every RUN cycle with both valid, saturating at 255.

RUN state, write outputs:
- At the edge after a transfer, the outputs present the accepted write for exactly one cycle:
  - reg_write = 1
  - write_addr = the request's address
  - For a core request with core_imm = 1: immediate = 1, immediate_val = core_data, data_in = 0, zero_store = 0.
  - For all other requests: immediate = 0, data_in = the request's data, immediate_val = 0, zero_store = the request's zero flag.
- With no transfer, the next cycle has reg_write = 0 and all other write outputs = 0.
- Throughput is one write per cycle. Latency is 1 cycle from acceptance to reg_write.

Clear:
- clear = 1 at an edge in RUN: state goes to INIT, cnt to 0.
- That same edge carries no transfer (ready is 0 whenever clear = 1).
- A write already registered at that edge is still presented.
- clear during INIT restarts the count from 0.
- The rr pointer and conflict_cnt are preserved.

Reset mid-operation: asynchronous return to the reset values listed above. Any in-flight write is lost.

Boundary conditions:
- cnt is D+1 bits wide.
- write_addr wraps only by returning through INIT.
- Valid inputs are don't-care in INIT.
- Data inputs are sampled only on a transfer.

Test Plan:
1. Release reset, no requests -> reg_write = 1 with write_addr 0..7 and data_in = 0 on 8 consecutive cycles; init_busy falls after the 8th; then reg_write = 0.
2. RUN, core_valid with core_addr=5, core_data=0x3C, core_imm=1 -> core_ready = 1 that cycle; next cycle reg_write = 1, immediate = 1, immediate_val = 0x3C, write_addr = 5, data_in = 0.
3. RUN, core and mem both valid for 4 cycles (core 0x11 to r2, mem 0x22 to r3) -> grants alternate core, mem, core, mem; conflict_cnt = 4.
4. mem_valid with mem_zero = 1, mem_addr = 6, mem_data = 0xA5 -> next cycle zero_store = 1, data_in = 0xA5, immediate = 0.
5. Assert clear for 1 cycle while core_valid is held -> no grant that cycle; then 8 zeroing writes to r0..r7; then the core request is accepted.
6. Drop reset_n mid-INIT at cnt = 4 -> outputs go to 0 immediately; after release, the sequence restarts at write_addr 0.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 8x8 register file: zeroes all registers after reset/clear,
// then round-robin arbitrates core writeback and load-unit writes onto registered controls.
module regfile_write_scheduler #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         core_valid,
   output logic         core_ready,
   input  logic [D-1:0] core_addr,
   input  logic [W-1:0] core_data,
   input  logic         core_imm,
   input  logic         core_zero,
   input  logic         mem_valid,
   output logic         mem_ready,
   input  logic [D-1:0] mem_addr,
   input  logic [W-1:0] mem_data,
   input  logic         mem_zero,
   output logic         reg_write,
   output logic         zero_store,
   output logic         immediate,
   output logic [W-1:0] data_in,
   output logic [W-1:0] immediate_val,
   output logic [D-1:0] write_addr,
   output logic         init_busy,
   output logic [7:0]   conflict_cnt
);

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [D:0] LAST_ADDR = {1'b0, {D{1'b1}}};

   state_t       state;
   state_t       state_nxt;
   logic [D:0]   cnt;
   logic         last_mem;
   logic         core_xfer;
   logic         mem_xfer;
   logic         both_valid;

   logic         reg_write_nxt;
   logic         zero_store_nxt;
   logic         immediate_nxt;
   logic [W-1:0] data_in_nxt;
   logic [W-1:0] immediate_val_nxt;
   logic [D-1:0] write_addr_nxt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= INIT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         INIT:    if (!clear && cnt == LAST_ADDR) state_nxt = RUN;
         RUN:     if (clear) state_nxt = INIT;
         default: state_nxt = INIT;
      endcase
   end

   // last_mem = 1 means the load unit won most recently, so core takes the next tie.
   always_comb begin
      init_busy  = (state == INIT);
      core_ready = 1'b0;
      mem_ready  = 1'b0;
      if (state == RUN && !clear) begin
         if (core_valid && mem_valid) begin
            core_ready = last_mem;
            mem_ready  = !last_mem;
         end else begin
            core_ready = core_valid;
            mem_ready  = mem_valid;
         end
      end
   end

   assign core_xfer  = core_valid && core_ready;
   assign mem_xfer   = mem_valid && mem_ready;
   assign both_valid = core_valid && mem_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         last_mem     <= 1'b1;
         conflict_cnt <= 8'd0;
      end else begin
         if (clear)               cnt <= '0;
         else if (state == INIT)  cnt <= cnt + 1'b1;
         if (core_xfer)           last_mem <= 1'b0;
         else if (mem_xfer)       last_mem <= 1'b1;
         if (state == RUN && both_valid) conflict_cnt <= sat_inc(conflict_cnt);
      end
   end

   always_comb begin
      reg_write_nxt     = 1'b0;
      zero_store_nxt    = 1'b0;
      immediate_nxt     = 1'b0;
      data_in_nxt       = '0;
      immediate_val_nxt = '0;
      write_addr_nxt    = '0;
      if (state == INIT) begin
         reg_write_nxt  = 1'b1;
         write_addr_nxt = cnt[D-1:0];
      end else if (core_xfer) begin
         reg_write_nxt  = 1'b1;
         write_addr_nxt = core_addr;
         if (core_imm) begin
            immediate_nxt     = 1'b1;
            immediate_val_nxt = core_data;
         end else begin
            data_in_nxt    = core_data;
            zero_store_nxt = core_zero;
         end
      end else if (mem_xfer) begin
         reg_write_nxt  = 1'b1;
         write_addr_nxt = mem_addr;
         data_in_nxt    = mem_data;
         zero_store_nxt = mem_zero;
      end
   end

   // Register-file controls are launched one cycle after acceptance.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_write     <= 1'b0;
         zero_store    <= 1'b0;
         immediate     <= 1'b0;
         data_in       <= '0;
         immediate_val <= '0;
         write_addr    <= '0;
      end else begin
         reg_write     <= reg_write_nxt;
         zero_store    <= zero_store_nxt;
         immediate     <= immediate_nxt;
         data_in       <= data_in_nxt;
         immediate_val <= immediate_val_nxt;
         write_addr    <= write_addr_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: init sweep, immediate/load writes,
// round-robin ties, clear, mid-init reset and conflict counter saturation.
module tb_regfile_write_scheduler;

   localparam int W = 8;
   localparam int D = 3;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         clear;
   logic         core_valid;
   logic         core_ready;
   logic [D-1:0] core_addr;
   logic [W-1:0] core_data;
   logic         core_imm;
   logic         core_zero;
   logic         mem_valid;
   logic         mem_ready;
   logic [D-1:0] mem_addr;
   logic [W-1:0] mem_data;
   logic         mem_zero;
   logic         reg_write;
   logic         zero_store;
   logic         immediate;
   logic [W-1:0] data_in;
   logic [W-1:0] immediate_val;
   logic [D-1:0] write_addr;
   logic         init_busy;
   logic [7:0]   conflict_cnt;

   int checks = 0;
   int failures = 0;

   regfile_write_scheduler #(.W(W), .D(D)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .core_valid(core_valid), .core_ready(core_ready), .core_addr(core_addr),
      .core_data(core_data), .core_imm(core_imm), .core_zero(core_zero),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_data(mem_data), .mem_zero(mem_zero),
      .reg_write(reg_write), .zero_store(zero_store), .immediate(immediate),
      .data_in(data_in), .immediate_val(immediate_val), .write_addr(write_addr),
      .init_busy(init_busy), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_write(input string tag, input logic rw, input logic [D-1:0] a,
                            input logic [W-1:0] d, input logic imm, input logic [W-1:0] iv,
                            input logic zs);
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(rw));
      chk({tag, ".write_addr"}, 32'(write_addr), 32'(a));
      chk({tag, ".data_in"}, 32'(data_in), 32'(d));
      chk({tag, ".immediate"}, 32'(immediate), 32'(imm));
      chk({tag, ".immediate_val"}, 32'(immediate_val), 32'(iv));
      chk({tag, ".zero_store"}, 32'(zero_store), 32'(zs));
   endtask

   initial begin
      reset_n = 1'b0; clear = 1'b0;
      core_valid = 1'b0; core_addr = '0; core_data = '0; core_imm = 1'b0; core_zero = 1'b0;
      mem_valid = 1'b0; mem_addr = '0; mem_data = '0; mem_zero = 1'b0;
      #2;
      chk_write("reset", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("reset.init_busy", 32'(init_busy), 32'd1);
      chk("reset.core_ready", 32'(core_ready), 32'd0);
      chk("reset.mem_ready", 32'(mem_ready), 32'd0);
      chk("reset.conflict_cnt", 32'(conflict_cnt), 32'd0);
      step(); step();
      @(negedge clk);
      reset_n = 1'b1;

      // init sweep after reset
      for (int i = 0; i < 8; i++) begin
         step();
         chk_write($sformatf("init%0d", i), 1'b1, D'(i), 8'h00, 1'b0, 8'h00, 1'b0);
         chk($sformatf("init%0d.init_busy", i), 32'(init_busy), (i < 7) ? 32'd1 : 32'd0);
      end
      step();
      chk("idle.reg_write", 32'(reg_write), 32'd0);

      // core immediate write
      core_valid = 1'b1; core_addr = 3'd5; core_data = 8'h3C; core_imm = 1'b1;
      #1;
      chk("imm.core_ready", 32'(core_ready), 32'd1);
      chk("imm.mem_ready", 32'(mem_ready), 32'd0);
      step();
      core_valid = 1'b0; core_imm = 1'b0;
      chk_write("imm", 1'b1, 3'd5, 8'h00, 1'b1, 8'h3C, 1'b0);
      step();
      chk_write("imm_after", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);

      // load with zero flag
      mem_valid = 1'b1; mem_addr = 3'd6; mem_data = 8'hA5; mem_zero = 1'b1;
      #1;
      chk("ld.mem_ready", 32'(mem_ready), 32'd1);
      chk("ld.core_ready", 32'(core_ready), 32'd0);
      step();
      mem_valid = 1'b0; mem_zero = 1'b0;
      chk_write("ld", 1'b1, 3'd6, 8'hA5, 1'b0, 8'h00, 1'b1);

      // ties alternate; load won last, so core goes first
      core_valid = 1'b1; core_addr = 3'd2; core_data = 8'h11;
      mem_valid = 1'b1;  mem_addr = 3'd3;  mem_data = 8'h22;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("tie%0d.core_ready", k), 32'(core_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("tie%0d.mem_ready", k), 32'(mem_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
         step();
         chk_write($sformatf("tie%0d", k), 1'b1, (k % 2 == 0) ? 3'd2 : 3'd3,
                   (k % 2 == 0) ? 8'h11 : 8'h22, 1'b0, 8'h00, 1'b0);
      end
      core_valid = 1'b0; mem_valid = 1'b0;
      chk("tie.conflict_cnt", 32'(conflict_cnt), 32'd4);
      step();
      chk("tie_after.reg_write", 32'(reg_write), 32'd0);

      // clear with a held core request
      core_valid = 1'b1; core_addr = 3'd1; core_data = 8'h77; clear = 1'b1;
      #1;
      chk("clr.core_ready", 32'(core_ready), 32'd0);
      step();
      clear = 1'b0;
      chk("clr.reg_write", 32'(reg_write), 32'd0);
      chk("clr.init_busy", 32'(init_busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("clr_init%0d.core_ready", i), 32'(core_ready), 32'd0);
         step();
         chk_write($sformatf("clr_init%0d", i), 1'b1, D'(i), 8'h00, 1'b0, 8'h00, 1'b0);
      end
      #1;
      chk("clr_run.core_ready", 32'(core_ready), 32'd1);
      step();
      core_valid = 1'b0;
      chk_write("clr_run", 1'b1, 3'd1, 8'h77, 1'b0, 8'h00, 1'b0);
      chk("clr_run.conflict_cnt", 32'(conflict_cnt), 32'd4);

      // reset in the middle of an init sweep
      clear = 1'b1;
      step();
      clear = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("mid.write_addr_pre", 32'(write_addr), 32'd3);
      reset_n = 1'b0;
      #1;
      chk_write("mid_rst", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("mid_rst.conflict_cnt", 32'(conflict_cnt), 32'd0);
      chk("mid_rst.init_busy", 32'(init_busy), 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk_write($sformatf("rinit%0d", i), 1'b1, D'(i), 8'h00, 1'b0, 8'h00, 1'b0);
      end

      // after reset core wins the first tie; hold the tie to saturate the counter
      core_valid = 1'b1; mem_valid = 1'b1;
      #1;
      chk("rst_tie.core_ready", 32'(core_ready), 32'd1);
      chk("rst_tie.mem_ready", 32'(mem_ready), 32'd0);
      for (int i = 0; i < 254; i++) step();
      chk("sat.conflict_254", 32'(conflict_cnt), 32'd254);
      step();
      chk("sat.conflict_255", 32'(conflict_cnt), 32'd255);
      for (int i = 0; i < 5; i++) step();
      chk("sat.conflict_hold", 32'(conflict_cnt), 32'd255);
      core_valid = 1'b0; mem_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
